// File: rtl/mips_chk_pkg.sv
// Shared types and constants for the IITK_MIPS result checker.
package mips_chk_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_STABLE,
      ST_SIZE_CHK,
      ST_SCAN,
      ST_SUM_CHK,
      ST_DONE
   } state_e;

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_ORDER   = 3'd1;
   localparam logic [2:0] ERR_SUM     = 3'd2;
   localparam logic [2:0] ERR_SIZE    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   localparam int IDX_W    = 4;
   localparam int SETTLE_W = 16;
   localparam int CYC_W    = 32;

endpackage

// File: rtl/mips_result_checker_stable_detect.sv
// Captures a snapshot of a wide bus and pulses once it has held steady for COUNT matching cycles.
module stable_detect #(
   parameter int WIDTH = 8,
   parameter int COUNT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   output logic             stable_pulse,
   output logic [WIDTH-1:0] snapshot
);

   localparam int CNT_W = $clog2(COUNT + 1);

   logic [WIDTH-1:0] snap_q, snap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match;

   always_comb begin
      snap_d       = snap_q;
      cnt_d        = cnt_q;
      stable_pulse = 1'b0;
      match        = (data_in == snap_q);
      if (en) begin
         if (!match) begin
            snap_d = data_in;
            cnt_d  = '0;
         end else begin
            if (cnt_q == CNT_W'(COUNT - 1))
               stable_pulse = 1'b1;
            if (cnt_q != CNT_W'(COUNT))
               cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
         cnt_q  <= '0;
      end else begin
         snap_q <= snap_d;
         cnt_q  <= cnt_d;
      end
   end

   assign snapshot = snap_q;

endmodule

// File: rtl/mips_result_checker.sv
// Monitors the IITK_MIPS sorted-array outputs: waits for them to settle, then checks
// signed ascending order, checksum and size, and latches a sticky verdict.
//
// state          | meaning
// ST_WAIT_STABLE | tracking inputs until settled, or timing out
// ST_SIZE_CHK    | validate snapshot size, latch settle_cycles
// ST_SCAN        | one element per cycle: accumulate and order-compare
// ST_SUM_CHK     | compare accumulated sum to exp_sum
// ST_DONE        | verdict held until reset
module mips_result_checker
   import mips_chk_pkg::*;
#(
   parameter int N_ELEM         = 10,
   parameter int DATA_W         = 32,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_ELEM*DATA_W-1:0] arr_flat,
   input  logic [DATA_W-1:0]        arr_size,
   input  logic [DATA_W-1:0]        exp_sum,
   output logic                     done,
   output logic                     pass,
   output logic [2:0]               err_code,
   output logic [IDX_W-1:0]         err_index,
   output logic [SETTLE_W-1:0]      settle_cycles
);

   localparam int SNAP_W = N_ELEM*DATA_W + DATA_W;

   state_e                state_q, state_d;
   logic [CYC_W-1:0]      cyc_q, cyc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      last_q, last_d;
   logic [DATA_W-1:0]     sum_q, sum_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic [2:0]            err_code_q, err_code_d;
   logic [IDX_W-1:0]      err_index_q, err_index_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;

   logic                  stable_pulse;
   logic [SNAP_W-1:0]     snap;
   logic [DATA_W-1:0]     snap_size;
   logic [DATA_W-1:0]     elem [N_ELEM];
   logic [IDX_W-1:0]      nxt_idx;
   logic [DATA_W-1:0]     cur_elem, nxt_elem;

   stable_detect #(
      .WIDTH (SNAP_W),
      .COUNT (STABLE_CYCLES)
   ) u_stable_detect (
      .clk          (clk),
      .reset        (reset),
      .en           (state_q == ST_WAIT_STABLE),
      .data_in      ({arr_flat, arr_size}),
      .stable_pulse (stable_pulse),
      .snapshot     (snap)
   );

   assign snap_size = snap[DATA_W-1:0];

   for (genvar g = 0; g < N_ELEM; g++) begin : g_elem
      assign elem[g] = snap[DATA_W + g*DATA_W +: DATA_W];
   end

   // Clamp keeps the neighbour read in range; it is only used when idx < last.
   assign nxt_idx  = (idx_q >= IDX_W'(N_ELEM - 1)) ? idx_q : idx_q + IDX_W'(1);
   assign cur_elem = elem[idx_q];
   assign nxt_elem = elem[nxt_idx];

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      idx_d       = idx_q;
      last_d      = last_q;
      sum_d       = sum_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_code_d  = err_code_q;
      err_index_d = err_index_q;
      settle_d    = settle_q;

      case (state_q)
         ST_WAIT_STABLE: begin
            if (cyc_q != '1)
               cyc_d = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(TIMEOUT_CYCLES - 1)) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               pass_d     = 1'b0;
               err_code_d = ERR_TIMEOUT;
            end else if (stable_pulse) begin
               state_d = ST_SIZE_CHK;
            end
         end
         ST_SIZE_CHK: begin
            // SCAN starts on the next edge, hence the +1.
            settle_d = (cyc_q >= CYC_W'(16'hFFFF)) ? 16'hFFFF
                                                   : SETTLE_W'(cyc_q + CYC_W'(1));
            if (snap_size == '0 || snap_size > DATA_W'(N_ELEM)) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               pass_d     = 1'b0;
               err_code_d = ERR_SIZE;
            end else begin
               idx_d   = '0;
               sum_d   = '0;
               last_d  = snap_size[IDX_W-1:0] - IDX_W'(1);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            sum_d = sum_q + cur_elem;
            if (idx_q != last_q && $signed(cur_elem) > $signed(nxt_elem)) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               pass_d      = 1'b0;
               err_code_d  = ERR_ORDER;
               err_index_d = idx_q;
            end else if (idx_q == last_q) begin
               state_d = ST_SUM_CHK;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_SUM_CHK: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (sum_q == exp_sum) begin
               pass_d     = 1'b1;
               err_code_d = ERR_OK;
            end else begin
               pass_d     = 1'b0;
               err_code_d = ERR_SUM;
            end
         end
         ST_DONE: begin
         end
         default: state_d = ST_WAIT_STABLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_WAIT_STABLE;
         cyc_q       <= '0;
         idx_q       <= '0;
         last_q      <= '0;
         sum_q       <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_code_q  <= ERR_OK;
         err_index_q <= '0;
         settle_q    <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         sum_q       <= sum_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_code_q  <= err_code_d;
         err_index_q <= err_index_d;
         settle_q    <= settle_d;
      end
   end

   assign done          = done_q;
   assign pass          = pass_q;
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;
   assign settle_cycles = settle_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Directed bench for mips_result_checker; cycle counts are edges after the last reset-high edge.
module tb_mips_result_checker;

   localparam int N  = 10;
   localparam int DW = 32;
   localparam int SC = 16;
   localparam int TO = 200;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N*DW-1:0] arr_flat = '0;
   logic [DW-1:0]   arr_size = '0;
   logic [DW-1:0]   exp_sum = '0;
   logic            done;
   logic            pass;
   logic [2:0]      err_code;
   logic [3:0]      err_index;
   logic [15:0]     settle_cycles;

   int checks = 0;
   int errors = 0;
   int vals [N];
   int n;

   mips_result_checker #(
      .N_ELEM         (N),
      .DATA_W         (DW),
      .STABLE_CYCLES  (SC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .arr_flat      (arr_flat),
      .arr_size      (arr_size),
      .exp_sum       (exp_sum),
      .done          (done),
      .pass          (pass),
      .err_code      (err_code),
      .err_index     (err_index),
      .settle_cycles (settle_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply(input int size, input int sum);
      for (int i = 0; i < N; i++)
         arr_flat[i*DW +: DW] = vals[i];
      arr_size = size;
      exp_sum  = sum;
   endtask

   task automatic reset_dut();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic wait_done(input int start, input int max, output int cnt);
      cnt = start;
      while (!done && cnt < max) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_code, 0);
      check("rst_idx", err_index, 0);
      check("rst_settle", settle_cycles, 0);

      // passing array: done at 10 + SC + 3
      vals = '{1,2,3,4,5,6,7,8,9,10};
      apply(10, 55);
      reset_dut();
      wait_done(0, 100, n);
      check("pass_cyc", n, 29);
      check("pass_pass", pass, 1);
      check("pass_err", err_code, 0);
      check("pass_idx", err_index, 0);
      check("pass_settle", settle_cycles, 18);

      vals = '{1,2,3,9,4,5,6,7,8,10};
      apply(10, 55);
      reset_dut();
      wait_done(0, 100, n);
      check("order_cyc", n, 22);
      check("order_err", err_code, 1);
      check("order_idx", err_index, 3);
      check("order_pass", pass, 0);

      vals = '{1,2,3,4,5,6,7,8,9,10};
      apply(10, 56);
      reset_dut();
      wait_done(0, 100, n);
      check("sum_cyc", n, 29);
      check("sum_err", err_code, 2);
      check("sum_pass", pass, 0);

      apply(0, 0);
      reset_dut();
      wait_done(0, 100, n);
      check("size0_cyc", n, 18);
      check("size0_err", err_code, 3);

      apply(11, 55);
      reset_dut();
      wait_done(0, 100, n);
      check("size11_cyc", n, 18);
      check("size11_err", err_code, 3);
      check("size11_pass", pass, 0);

      // negative values must be ordered as signed
      vals = '{-5,-1,0,2,7,100,0,0,0,0};
      apply(5, 3);
      reset_dut();
      wait_done(0, 100, n);
      check("signed_cyc", n, 24);
      check("signed_pass", pass, 1);
      check("signed_err", err_code, 0);

      vals = '{42,1,0,0,0,0,0,0,0,0};
      apply(1, 42);
      reset_dut();
      wait_done(0, 100, n);
      check("size1_cyc", n, 20);
      check("size1_pass", pass, 1);

      // input change after capture is ignored; verdict is sticky
      vals = '{1,2,3,4,5,6,7,8,9,10};
      apply(10, 55);
      reset_dut();
      repeat (20) @(negedge clk);
      vals[0] = 99;
      apply(10, 55);
      wait_done(20, 100, n);
      check("late_cyc", n, 29);
      check("late_pass", pass, 1);
      vals[5] = 0;
      apply(3, 1);
      repeat (5) @(negedge clk);
      check("sticky_done", done, 1);
      check("sticky_pass", pass, 1);
      check("sticky_err", err_code, 0);

      // reset mid-scan on a failing array
      vals = '{1,2,3,4,5,6,7,8,9,10};
      apply(10, 0);
      reset_dut();
      repeat (23) @(negedge clk);
      check("mid_settle", settle_cycles, 18);
      check("mid_done", done, 0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_done", done, 0);
      check("mid_rst_settle", settle_cycles, 0);
      check("mid_rst_err", err_code, 0);
      apply(10, 55);
      @(negedge clk) reset = 1'b0;
      wait_done(0, 100, n);
      check("mid_pass_cyc", n, 29);
      check("mid_pass_pass", pass, 1);
      check("mid_pass_err", err_code, 0);

      // toggling input never settles -> timeout
      vals = '{1,2,3,4,5,6,7,8,9,10};
      apply(10, 55);
      reset_dut();
      n = 0;
      while (!done && n < 250) begin
         @(negedge clk);
         n++;
         if (n % 4 == 0)
            arr_flat[0] = ~arr_flat[0];
      end
      check("to_cyc", n, TO);
      check("to_err", err_code, 4);
      check("to_pass", pass, 0);
      check("to_settle", settle_cycles, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
